// File: rtl/fifo_rr_merge.sv
// Round-robin merge of two first-word-fall-through FIFOs into one valid/ready stream.
// FIFO pops depend only on registered buffer occupancy and arbitration state, never on out_ready.
module fifo_rr_merge #(
    parameter int C_WIDTH = 28,
    parameter int C_BURST = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [C_WIDTH-1:0] in0_dout,
    input  logic               in0_empty,
    output logic               in0_rd_en,
    input  logic [C_WIDTH-1:0] in1_dout,
    input  logic               in1_empty,
    output logic               in1_rd_en,
    output logic [C_WIDTH-1:0] out_data,
    output logic               out_src,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam logic [3:0] BURST_MAX = 4'(C_BURST);

    logic [C_WIDTH-1:0] head_data_r;
    logic [C_WIDTH-1:0] tail_data_r;
    logic               head_src_r;
    logic               tail_src_r;
    logic [1:0]         count_r;
    logic               valid_r;
    logic               owner_r;
    logic [3:0]         burst_r;

    logic               space_s;
    logic               sel_s;
    logic               grant_s;
    logic               accept_s;
    logic [C_WIDTH-1:0] push_data_s;
    logic [1:0]         count_nxt_s;
    logic               owner_nxt_s;
    logic [3:0]         burst_nxt_s;

    // Arbitration: pick a source from registered owner/burst state and the empty flags
    always_comb begin
        space_s = (count_r < 2'd2);
        sel_s   = owner_r;
        grant_s = 1'b0;
        if (!in0_empty && !in1_empty) begin
            sel_s   = (burst_r < BURST_MAX) ? owner_r : ~owner_r;
            grant_s = space_s && !rst;
        end else if (!in0_empty) begin
            sel_s   = 1'b0;
            grant_s = space_s && !rst;
        end else if (!in1_empty) begin
            sel_s   = 1'b1;
            grant_s = space_s && !rst;
        end else begin
            sel_s   = owner_r;
            grant_s = 1'b0;
        end
    end

    assign in0_rd_en   = grant_s && !sel_s;
    assign in1_rd_en   = grant_s && sel_s;
    assign push_data_s = sel_s ? in1_dout : in0_dout;
    assign accept_s    = valid_r && out_ready;

    // Owner/burst update: a switch of owner restarts the burst at one pop
    always_comb begin
        owner_nxt_s = owner_r;
        burst_nxt_s = burst_r;
        if (grant_s) begin
            if (sel_s == owner_r) begin
                owner_nxt_s = owner_r;
                burst_nxt_s = (burst_r < BURST_MAX) ? (burst_r + 4'd1) : burst_r;
            end else begin
                owner_nxt_s = sel_s;
                burst_nxt_s = 4'd1;
            end
        end else begin
            owner_nxt_s = owner_r;
            burst_nxt_s = burst_r;
        end
    end

    // Buffer occupancy: push and accept in the same cycle cancel out
    always_comb begin
        case ({grant_s, accept_s})
            2'b10:   count_nxt_s = count_r + 2'd1;
            2'b01:   count_nxt_s = count_r - 2'd1;
            default: count_nxt_s = count_r;
        endcase
    end

    // State registers and the two-entry output buffer (head drives the outputs)
    always_ff @(posedge clk) begin
        if (rst) begin
            head_data_r <= '0;
            tail_data_r <= '0;
            head_src_r  <= 1'b0;
            tail_src_r  <= 1'b0;
            count_r     <= 2'd0;
            valid_r     <= 1'b0;
            owner_r     <= 1'b0;
            burst_r     <= 4'd0;
        end else begin
            count_r <= count_nxt_s;
            valid_r <= (count_nxt_s != 2'd0);
            owner_r <= owner_nxt_s;
            burst_r <= burst_nxt_s;
            case (count_r)
                2'd0: begin
                    if (grant_s) begin
                        head_data_r <= push_data_s;
                        head_src_r  <= sel_s;
                    end
                end
                2'd1: begin
                    if (grant_s && accept_s) begin
                        head_data_r <= push_data_s;
                        head_src_r  <= sel_s;
                    end else if (grant_s) begin
                        tail_data_r <= push_data_s;
                        tail_src_r  <= sel_s;
                    end
                end
                2'd2: begin
                    if (accept_s) begin
                        head_data_r <= tail_data_r;
                        head_src_r  <= tail_src_r;
                    end
                end
                default: begin
                    head_data_r <= head_data_r;
                end
            endcase
        end
    end

    assign out_data  = head_data_r;
    assign out_src   = head_src_r;
    assign out_valid = valid_r;

endmodule

// File: tb/tb_fifo_rr_merge.sv
// Self-checking bench for fifo_rr_merge: queue-level reference model plus directed
// scenarios with literal expectations and a randomized traffic phase.
module tb_fifo_rr_merge;

    localparam int W = 28;
    localparam int B = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in0_dout;
    logic         in0_empty;
    logic         in0_rd_en;
    logic [W-1:0] in1_dout;
    logic         in1_empty;
    logic         in1_rd_en;
    logic [W-1:0] out_data;
    logic         out_src;
    logic         out_valid;
    logic         out_ready;

    always #5 clk = ~clk;

    fifo_rr_merge #(.C_WIDTH(W), .C_BURST(B)) dut (
        .clk      (clk),
        .rst      (rst),
        .in0_dout (in0_dout),
        .in0_empty(in0_empty),
        .in0_rd_en(in0_rd_en),
        .in1_dout (in1_dout),
        .in1_empty(in1_empty),
        .in1_rd_en(in1_rd_en),
        .out_data (out_data),
        .out_src  (out_src),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    typedef struct packed {
        logic         src;
        logic [W-1:0] data;
    } ent_t;

    int           tests = 0;
    int           fails = 0;
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    ent_t         mq[$];
    int           m_owner;
    int           m_burst;
    logic [W-1:0] log_d[$];
    logic         log_s[$];
    int           pops0;
    int           pops1;
    logic         last_rd0;
    logic         last_rd1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive_fifos();
        in0_empty = (q0.size() == 0);
        in1_empty = (q1.size() == 0);
        in0_dout  = (q0.size() != 0) ? q0[0] : '0;
        in1_dout  = (q1.size() != 0) ? q1[0] : '0;
    endtask

    // One clock of model + DUT: check grants before the edge, buffer outputs after it
    task automatic step(input bit do_rst);
        int   g;
        logic acc;
        rst = do_rst;
        drive_fifos();
        #1;
        g = -1;
        if (!do_rst && mq.size() < 2) begin
            if (q0.size() != 0 && q1.size() != 0) g = (m_burst < B) ? m_owner : 1 - m_owner;
            else if (q0.size() != 0) g = 0;
            else if (q1.size() != 0) g = 1;
        end
        last_rd0 = in0_rd_en;
        last_rd1 = in1_rd_en;
        check("rd_en0", {31'd0, in0_rd_en}, {31'd0, g == 0});
        check("rd_en1", {31'd0, in1_rd_en}, {31'd0, g == 1});
        acc = (mq.size() != 0) && out_ready;
        if (acc && !do_rst) begin
            log_d.push_back(out_data);
            log_s.push_back(out_src);
        end
        @(posedge clk);
        #1;
        if (do_rst) begin
            mq.delete();
            m_owner = 0;
            m_burst = 0;
        end else begin
            if (acc) void'(mq.pop_front());
            if (g == 0) begin
                mq.push_back({1'b0, q0.pop_front()});
                pops0++;
            end else if (g == 1) begin
                mq.push_back({1'b1, q1.pop_front()});
                pops1++;
            end
            if (g >= 0) begin
                if (g == m_owner) begin
                    m_burst = (m_burst < B) ? m_burst + 1 : m_burst;
                end else begin
                    m_owner = g;
                    m_burst = 1;
                end
            end
        end
        check("out_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
        if (mq.size() != 0) begin
            check("out_data", {4'd0, out_data}, {4'd0, mq[0].data});
            check("out_src", {31'd0, out_src}, {31'd0, mq[0].src});
        end
    endtask

    task automatic clear_log();
        log_d.delete();
        log_s.delete();
        pops0 = 0;
        pops1 = 0;
    endtask

    task automatic do_reset();
        out_ready = 1'b0;
        step(1'b1);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", {4'd0, out_data}, 32'd0);
        check("rst_src", {31'd0, out_src}, 32'd0);
    endtask

    task automatic drain(input int maxc);
        out_ready = 1'b1;
        for (int i = 0; i < maxc; i++) begin
            if (q0.size() == 0 && q1.size() == 0 && mq.size() == 0) break;
            step(1'b0);
        end
        check("drain_left", q0.size() + q1.size() + mq.size(), 32'd0);
    endtask

    initial begin
        logic [W-1:0] exp2[8];
        logic         exps2[8];
        logic [W-1:0] exp3[6];
        int           n;

        m_owner   = 0;
        m_burst   = 0;
        out_ready = 1'b0;
        clear_log();
        rst = 1'b1;
        drive_fifos();
        do_reset();
        do_reset();

        // Single-source streaming
        clear_log();
        q0 = '{28'hA, 28'hB, 28'hC};
        drain(20);
        check("t1_pops0", pops0, 32'd3);
        check("t1_pops1", pops1, 32'd0);
        check("t1_len", log_d.size(), 32'd3);
        if (log_d.size() == 3) begin
            check("t1_w0", {4'd0, log_d[0]}, 32'hA);
            check("t1_w1", {4'd0, log_d[1]}, 32'hB);
            check("t1_w2", {4'd0, log_d[2]}, 32'hC);
            check("t1_src", {29'd0, log_s[0], log_s[1], log_s[2]}, 32'd0);
        end

        // Fairness with both sources busy
        do_reset();
        clear_log();
        q0 = '{28'h10, 28'h11, 28'h12, 28'h13};
        q1 = '{28'h20, 28'h21, 28'h22, 28'h23};
        exp2  = '{28'h10, 28'h11, 28'h20, 28'h21, 28'h12, 28'h13, 28'h22, 28'h23};
        exps2 = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        drain(30);
        check("t2_len", log_d.size(), 32'd8);
        n = (log_d.size() < 8) ? log_d.size() : 8;
        for (int i = 0; i < n; i++) begin
            check("t2_word", {4'd0, log_d[i]}, {4'd0, exp2[i]});
            check("t2_src", {31'd0, log_s[i]}, {31'd0, exps2[i]});
        end

        // Backpressure: buffer fills to two, then pops stop
        do_reset();
        clear_log();
        q0 = '{28'h10, 28'h11, 28'h12};
        q1 = '{28'h20, 28'h21, 28'h22};
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) step(1'b0);
        check("t3_pops", pops0 + pops1, 32'd2);
        check("t3_hold", {4'd0, out_data}, 32'h10);
        check("t3_valid", {31'd0, out_valid}, 32'd1);
        exp3 = '{28'h10, 28'h11, 28'h20, 28'h21, 28'h12, 28'h22};
        drain(30);
        check("t3_len", log_d.size(), 32'd6);
        n = (log_d.size() < 6) ? log_d.size() : 6;
        for (int i = 0; i < n; i++) check("t3_word", {4'd0, log_d[i]}, {4'd0, exp3[i]});

        // Burst limit ignored when alone, then honoured once in1 arrives
        do_reset();
        clear_log();
        q0 = '{28'h50, 28'h51, 28'h52, 28'h53, 28'h54, 28'h55, 28'h56};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0);
            check("t4_alone", {31'd0, last_rd0}, 32'd1);
        end
        q1.push_back(28'h60);
        step(1'b0);
        check("t4_switch", {30'd0, last_rd1, last_rd0}, 32'd2);

        // Steady state at one buffered word: one word per cycle
        clear_log();
        for (int i = 0; i < 6; i++) q0.push_back(28'h70 + 28'(i));
        for (int i = 0; i < 6; i++) step(1'b0);
        check("t5_pops", pops0 + pops1, 32'd6);
        check("t5_accepts", log_d.size(), 32'd6);
        drain(30);

        // Reset mid-stream with a full buffer
        do_reset();
        q0 = '{28'h80, 28'h81, 28'h82, 28'h83};
        q1 = '{28'h90, 28'h91, 28'h92, 28'h93};
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b0);
        step(1'b1);
        check("t6_rd_in_rst", {30'd0, last_rd1, last_rd0}, 32'd0);
        check("t6_valid", {31'd0, out_valid}, 32'd0);
        step(1'b0);
        check("t6_first", {30'd0, last_rd1, last_rd0}, 32'd1);
        drain(40);

        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            if (q0.size() < 6 && $urandom_range(0, 2) == 0) q0.push_back(28'($urandom));
            if (q1.size() < 6 && $urandom_range(0, 2) == 0) q1.push_back(28'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            step($urandom_range(0, 499) == 0);
        end
        drain(60);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
